// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: default geometry and the
// push/pop operation encoding used by the occupancy counter.
// No logic of its own; imported by the interface and the RTL modules.
package sync_fifo_pkg;

    localparam int SYNC_FIFO_DATA_WIDTH_DEF = 8;
    localparam int SYNC_FIFO_ADDR_WIDTH_DEF = 4;
    localparam int SYNC_FIFO_AF_SLOTS_DEF   = 4;
    localparam int SYNC_FIFO_AE_SLOTS_DEF   = 4;

    // {push, pop} packed into one code so the counter update reads as a case.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the FIFO: write request + data, read request,
// registered read data and the four occupancy flags.
// master = the side driving WR/RD; slave = the FIFO itself.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH_DEF
);
    logic                  WR;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  RD;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL_FLAG;
    logic                  ALMOST_EMPTY_FLAG;

    modport master (
        output WR, WR_DATA, RD,
        input  RD_DATA, FULL, EMPTY, ALMOST_FULL_FLAG, ALMOST_EMPTY_FLAG
    );

    modport slave (
        input  WR, WR_DATA, RD,
        output RD_DATA, FULL, EMPTY, ALMOST_FULL_FLAG, ALMOST_EMPTY_FLAG
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register file: one write port, one registered read port.
// Read latency 1 cycle; rdata holds when re is low. No backpressure (always accepts).
// Ports: clk, rst (sync active-high, clears rdata only), we/waddr/wdata, re/raddr/rdata.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_WIDTH_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the same address being written returns the old
    // word, which is exactly the pop-while-full ordering the FIFO needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2^ADDR_WIDTH words, with FULL/EMPTY and programmable almost flags.
// Read data 1 cycle after a pop; flags follow the registered count (1 cycle after the edge).
// Backpressure: WR while FULL (without RD) and RD while EMPTY are silently dropped.
// Ports: i_CLK, i_RST_n (sync, ACTIVE-HIGH despite the name), bus (sync_fifo_if.slave).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH              = SYNC_FIFO_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH              = SYNC_FIFO_ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL_LEFT_SLOTS  = SYNC_FIFO_AF_SLOTS_DEF,
    parameter int ALMOST_EMPTY_AVAI_SLOTS = SYNC_FIFO_AE_SLOTS_DEF
)(
    input  logic       i_CLK,
    input  logic       i_RST_n,
    sync_fifo_if.slave bus
);
    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   free_slots;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    fifo_op_e              op;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A write into a full FIFO is allowed when a read frees a slot on the
    // same edge; a read of an empty FIFO is never allowed, so WR+RD at empty
    // degenerates into a plain push.
    assign push = bus.WR && (!full || bus.RD);
    assign pop  = bus.RD && !empty;
    assign op   = fifo_op_e'({push, pop});

    always_ff @(posedge i_CLK) begin
        if (i_RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (i_CLK),
        .rst   (i_RST_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.WR_DATA),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // All flags decode the same registered count, so they can never disagree.
    assign free_slots            = DEPTH_CNT - count;
    assign bus.RD_DATA           = rd_data;
    assign bus.FULL              = full;
    assign bus.EMPTY             = empty;
    assign bus.ALMOST_FULL_FLAG  = (int'(free_slots) <= ALMOST_FULL_LEFT_SLOTS);
    assign bus.ALMOST_EMPTY_FLAG = (int'(count) <= ALMOST_EMPTY_AVAI_SLOTS);

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo (default parameters: 8-bit data, 16 deep, thresholds 4/4).
// A queue scoreboard holds the words the FIFO should contain; each pop pulls the
// expected read data from it, and the expected flags are decoded from its size.
module tb_sync_fifo;

    logic i_CLK;
    logic i_RST_n;

    sync_fifo_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo #(
        .DATA_WIDTH              (8),
        .ADDR_WIDTH              (4),
        .ALMOST_FULL_LEFT_SLOTS  (4),
        .ALMOST_EMPTY_AVAI_SLOTS (4)
    ) dut (
        .i_CLK   (i_CLK),
        .i_RST_n (i_RST_n),
        .bus     (bus)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    logic [7:0] sb [$];
    logic [7:0] exp_rd;
    int         n_cmp;
    int         n_err;

    wire [3:0] flags_obs = {bus.FULL, bus.EMPTY, bus.ALMOST_FULL_FLAG, bus.ALMOST_EMPTY_FLAG};

    // Reference decode of {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY} from occupancy.
    function automatic logic [3:0] exp_flags();
        int n;
        n = sb.size();
        return {n == 16, n == 0, (16 - n) <= 4, n <= 4};
    endfunction

    // Drive one cycle of requests from a negedge, update the scoreboard at the
    // posedge, and return at the following negedge with requests dropped.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic do_push;
        logic do_pop;
        bus.WR      = w;
        bus.WR_DATA = d;
        bus.RD      = r;
        do_push = w && (sb.size() != 16 || r);
        do_pop  = r && (sb.size() != 0);
        @(posedge i_CLK);
        if (do_pop)  exp_rd = sb.pop_front();
        if (do_push) sb.push_back(d);
        @(negedge i_CLK);
        bus.WR = 1'b0;
        bus.RD = 1'b0;
    endtask

    task automatic apply_reset(input logic w, input logic r);
        bus.WR      = w;
        bus.RD      = r;
        bus.WR_DATA = 8'h3C;
        i_RST_n     = 1'b1;
        @(posedge i_CLK);
        @(posedge i_CLK);
        sb.delete();
        exp_rd = 8'h00;
        @(negedge i_CLK);
        i_RST_n = 1'b0;
        bus.WR  = 1'b0;
        bus.RD  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (flags_obs !== 4'b0101) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0101", flags_obs);
        end
        n_cmp++;
        if (bus.RD_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h want 00", bus.RD_DATA);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 8'($urandom_range(1, 255)), 1'b0);
            n_cmp++;
            if (flags_obs !== exp_flags()) begin
                n_err++;
                $display("FAIL fill_flags[%0d]: got %b want %b", i, flags_obs, exp_flags());
            end
        end
        n_cmp++;
        if (sb.size() != 16 || bus.FULL !== 1'b1) begin
            n_err++;
            $display("FAIL fill_17th_ignored: full=%b model_count=%0d want 1/16", bus.FULL, sb.size());
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] first;
        first = sb[0];
        step(1'b1, 8'h00, 1'b1);
        n_cmp++;
        if (bus.RD_DATA !== first) begin
            n_err++;
            $display("FAIL full_rw_data: got %h want %h", bus.RD_DATA, first);
        end
        n_cmp++;
        if (flags_obs !== 4'b1010) begin
            n_err++;
            $display("FAIL full_rw_flags: got %b want 1010", flags_obs);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (bus.RD_DATA !== exp_rd) begin
                n_err++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, bus.RD_DATA, exp_rd);
            end
            n_cmp++;
            if (flags_obs !== exp_flags()) begin
                n_err++;
                $display("FAIL drain_flags[%0d]: got %b want %b", i, flags_obs, exp_flags());
            end
        end
        n_cmp++;
        if (bus.RD_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL drain_last_zero: got %h want 00", bus.RD_DATA);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (bus.RD_DATA !== 8'h00 || flags_obs !== 4'b0101) begin
                n_err++;
                $display("FAIL empty_read[%0d]: data %h flags %b want 00 0101", i, bus.RD_DATA, flags_obs);
            end
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'hA5, 1'b1);
        n_cmp++;
        if (flags_obs !== 4'b0001 || bus.RD_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL empty_rw: flags %b data %h want 0001 00", flags_obs, bus.RD_DATA);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (bus.RD_DATA !== 8'hA5) begin
            n_err++;
            $display("FAIL empty_rw_readback: got %h want a5", bus.RD_DATA);
        end
        n_cmp++;
        if (flags_obs !== 4'b0101) begin
            n_err++;
            $display("FAIL empty_rw_empty: got %b want 0101", flags_obs);
        end
    endtask

    task automatic test_back_to_back();
        logic w;
        logic r;
        for (int i = 0; i < 400; i++) begin
            // Phase-dependent bias walks the fill level across both ends.
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(w, 8'($urandom_range(0, 255)), r);
            n_cmp++;
            if (bus.RD_DATA !== exp_rd || flags_obs !== exp_flags()) begin
                n_err++;
                $display("FAIL b2b[%0d]: data %h flags %b want %h %b", i, bus.RD_DATA, flags_obs, exp_rd, exp_flags());
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'($urandom_range(1, 255)), 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (bus.RD_DATA !== exp_rd || flags_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_pre: data %h flags %b want %h 0000", bus.RD_DATA, flags_obs, exp_rd);
        end
        apply_reset(1'b1, 1'b1);
        n_cmp++;
        if (flags_obs !== 4'b0101 || bus.RD_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: flags %b data %h want 0101 00", flags_obs, bus.RD_DATA);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (flags_obs !== 4'b0101 || bus.RD_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL mid_read_ignored: flags %b data %h want 0101 00", flags_obs, bus.RD_DATA);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_rd      = 8'h00;
        i_RST_n     = 1'b1;
        bus.WR      = 1'b0;
        bus.RD      = 1'b0;
        bus.WR_DATA = 8'h00;
        @(negedge i_CLK);
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_empty_rw();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
